load_scheduler: RTL and testbench
=================================

// Module: load_scheduler
// PURPOSE
//  Shares the single serial program link into the tiny processor between NUM_REQ image sources.
//  Per grant: streams NUM_BYTES 13-bit load frames {1'b0, byte[7:0], addr[3:0]} to the frame serializer.
//  Then drives run mode and waits for processor done. Sits between demo-input logic and the serializer/mode pins.
// PARAMETERS
//  NUM_REQ      2     number of requesters (2..8)
//  NUM_BYTES    16    image bytes per load (1..16; frame address field is 4 bits)
//  TIMEOUT_CYC  1024  RUN watchdog limit in clk cycles (only with LOAD_TIMEOUT_EN)
// PORTS
//  clk         in   1             system clock
//  rst_n       in   1             asynchronous active-low reset
//  req_i       in   NUM_REQ       level request per source, held until its ack_o
//  grant_o     out  NUM_REQ       one-hot owner of the link; 0 when idle
//  rd_addr_o   out  4             byte index into the granted source's image
//  rd_data_i   in   NUM_REQ x 8   image byte per source (combinational on rd_addr_o)
//  frm_valid_o out  1             frame offered to serializer
//  frm_data_o  out  13            {1'b0, rd_data_i[owner], rd_addr_o}
//  frm_ready_i in   1             serializer accepts frame (transfer = valid & ready)
//  ser_busy_i  in   1             serializer still shifting a frame
//  done_i      in   1             processor finished execution
//  mode_o      out  2             00 idle, 01 load, 11 run
//  ack_o       out  NUM_REQ       1-cycle completion pulse to owner
//  err_o       out  1             1-cycle watchdog expiry pulse
// BEHAVIOUR
//  Reset (async, any state): state IDLE, grant_o=0, rd_addr_o=0, frm_valid_o=0, mode_o=00, ack_o=0, err_o=0, rr pointer=0.
//  FSM: IDLE -> ARB -> LOAD -> DRAIN -> RUN -> RELEASE -> IDLE.
//  IDLE: |req_i -> ARB next cycle.
//  ARB (1 cycle): round-robin pick from pointer upward; latch owner, grant_o set from next cycle.
//    Pointer = owner+1 mod NUM_REQ. Idle-to-grant latency is 2 cycles.
//  LOAD: frm_valid_o=1, mode_o=01.
//    frm_data_o stable while valid & !ready.
//    On transfer: rd_addr_o++. Transfer at addr NUM_BYTES-1 -> DRAIN, frm_valid_o drops the next cycle.
//  DRAIN: mode_o=01; ser_busy_i==0 -> RUN.
//  RUN: mode_o=11; done_i==1 -> RELEASE. done_i outside RUN is ignored.
//  RELEASE (1 cycle): ack_o[owner]=1, mode_o=00; next cycle grant_o=0, rd_addr_o=0, IDLE.
//  Requesters must drop req_i in the ack cycle; a still-high req is re-arbitrated fairly.
//  req_i drop mid-transaction: no abort, sequence completes and ack_o still pulses.
//  rd_addr_o wraps only via reset to 0 in RELEASE; it never exceeds NUM_BYTES-1.
//  Simultaneous requests: strict round-robin, each holder served once before a repeat.
// CONFIGURATION
//  LOAD_TIMEOUT_EN defined:
//    $clog2(TIMEOUT_CYC)-bit counter, cleared on RUN entry, counts in RUN.
//    Count == TIMEOUT_CYC-1 without done_i -> RELEASE with err_o=1 in the same cycle as ack_o.
//    done_i and expiry in the same cycle -> done wins, err_o=0.
//  Not defined: no counter, err_o tied 0, RUN waits indefinitely for done_i.
// STRUCTURE
//  Package load_sched_pkg: state_t enum; MODE_IDLE=2'b00, MODE_LOAD=2'b01, MODE_RUN=2'b11; FRAME_W=13; ADDR_W=4.
//  Sub-module rr_arbiter #(N): req, pointer -> one-hot grant, combinational; instantiated once.
//  Top holds the FSM, address counter, owner register, data mux, and the optional watchdog.
// TESTING
//  1. req_i=01, data[k]=8'hA0+k, ready=1: 16 frames, addr 0..15, frame 0 = 13'h0A00, mode 01; done_i -> ack_o=01, mode 00.
//  2. Backpressure: ready low 3 of every 4 cycles: frm_data_o held while stalled, exactly 16 transfers, no address skips.
//  3. req_i=11 held, ack each in turn: grant order 01,10,01,10; ack_o never on a non-owner.
//  4. done_i pulsed during LOAD/DRAIN: ignored; RUN entered and waits for a fresh done_i.
//  5. rst_n low mid-LOAD at addr 7: outputs reset immediately; after release with req=01, load restarts at addr 0.
//  6. LOAD_TIMEOUT_EN, TIMEOUT_CYC=8, no done_i: err_o and ack_o pulse together 8 cycles after RUN entry.
//     Without the macro, the block stays in RUN with err_o=0.

Source files
------------

// File: rtl/load_sched_pkg.sv
// Shared types and constants for the program-link load scheduler.
// The optional RUN watchdog is enabled by defining LOAD_TIMEOUT_EN.
package load_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN,
        ST_RELEASE
    } state_t;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b11;

    localparam int FRAME_W = 13;
    localparam int ADDR_W  = 4;

    // Mode pins are a pure function of the FSM state.
    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            ST_LOAD, ST_DRAIN: mode_of = MODE_LOAD;
            ST_RUN:            mode_of = MODE_RUN;
            default:           mode_of = MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr wins.
// Produces both a one-hot grant and the binary index of the winner.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    localparam int SUM_W = PTR_W + 1;

    logic [2*N-1:0]   req_dbl;
    logic [PTR_W-1:0] sel;
    logic [SUM_W-1:0] sum;
    logic             any;

    // Doubling the request vector turns the circular search into a linear one.
    always_comb begin
        req_dbl = {req, req};
        sel     = '0;
        any     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_dbl[int'(ptr) + k]) begin
                sel = PTR_W'(k);
                any = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, sel};
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
    end

    assign grant_idx = sum[PTR_W-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = any && (grant_idx == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/load_scheduler.sv
// Shares the serial program link between NUM_REQ image sources: arbitrate, stream
// NUM_BYTES load frames, run the processor, then acknowledge. Watchdog: LOAD_TIMEOUT_EN.
module load_scheduler
    import load_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int NUM_BYTES   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [ADDR_W-1:0]      rd_addr_o,
    input  logic [NUM_REQ*8-1:0]   rd_data_i,
    output logic                   frm_valid_o,
    output logic [FRAME_W-1:0]     frm_data_o,
    input  logic                   frm_ready_i,
    input  logic                   ser_busy_i,
    input  logic                   done_i,
    output logic [1:0]             mode_o,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic                   err_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_BYTES < 1 || NUM_BYTES > 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
            $error("load_scheduler: unsupported parameter set");
        end
    endgenerate

    state_t               state_reg, state_next;
    logic [PTR_W-1:0]     ptr_reg, ptr_next;
    logic [PTR_W-1:0]     owner_reg, owner_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]     arb_idx;
    logic [7:0]           src_byte [NUM_REQ];
    logic                 xfer;
    logic                 wd_expire;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req       (req_i),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
            assign src_byte[gi] = rd_data_i[gi*8 +: 8];
        end
    endgenerate

    assign xfer = (state_reg == ST_LOAD) && frm_ready_i;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        grant_next = grant_reg;
        addr_next  = addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req_i) state_next = ST_ARB;
            end
            ST_ARB: begin
                // A request withdrawn during the arbitration cycle simply returns to idle.
                if (|arb_grant) begin
                    owner_next = arb_idx;
                    grant_next = arb_grant;
                    ptr_next   = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : PTR_W'(arb_idx + 1'b1);
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (addr_reg == LAST_ADDR) state_next = ST_DRAIN;
                    else                       addr_next  = addr_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!ser_busy_i) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (done_i || wd_expire) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                grant_next = '0;
                addr_next  = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            grant_reg <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            grant_reg <= grant_next;
            addr_reg  <= addr_next;
        end
    end

`ifdef LOAD_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            err_reg, err_next;

    assign wd_expire = (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if (state_reg == ST_DRAIN && !ser_busy_i) begin
            wd_cnt_next = '0;
        end else if (state_reg == ST_RUN) begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
        end
        // done_i takes priority over a simultaneous expiry.
        err_next = (state_reg == ST_RUN) && !done_i && wd_expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
            err_reg    <= err_next;
        end
    end

    assign err_o = err_reg;
`else
    assign wd_expire = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign grant_o     = grant_reg;
    assign rd_addr_o   = addr_reg;
    assign frm_valid_o = (state_reg == ST_LOAD);
    assign frm_data_o  = {1'b0, src_byte[owner_reg], addr_reg};
    assign mode_o      = mode_of(state_reg);
    assign ack_o       = (state_reg == ST_RELEASE) ? grant_reg : '0;

endmodule

// File: tb/tb_load_scheduler.sv
// Directed self-checking bench for load_scheduler (2 sources, 16 bytes, watchdog limit 8).
// Build with LOAD_TIMEOUT_EN defined to exercise the watchdog expiry path.
module tb_load_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [1:0]  grant_o;
    logic [3:0]  rd_addr_o;
    logic [15:0] rd_data_i;
    logic        frm_valid_o;
    logic [12:0] frm_data_o;
    logic        frm_ready_i;
    logic        ser_busy_i;
    logic        done_i;
    logic [1:0]  mode_o;
    logic [1:0]  ack_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Source 0 image byte k = A0+k, source 1 image byte k = B0+k.
    assign rd_data_i = {8'hB0 | {4'h0, rd_addr_o}, 8'hA0 | {4'h0, rd_addr_o}};

    load_scheduler #(
        .NUM_REQ     (2),
        .NUM_BYTES   (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .grant_o     (grant_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .frm_valid_o (frm_valid_o),
        .frm_data_o  (frm_data_o),
        .frm_ready_i (frm_ready_i),
        .ser_busy_i  (ser_busy_i),
        .done_i      (done_i),
        .mode_o      (mode_o),
        .ack_o       (ack_o),
        .err_o       (err_o)
    );

    function automatic logic [12:0] exp_frame(input int owner, input int a);
        logic [7:0] b;
        b = ((owner == 0) ? 8'hA0 : 8'hB0) + 8'(a);
        return {1'b0, b, 4'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (grant_o == 2'b00 && cyc < 10) begin
            tick();
            cyc++;
        end
    endtask

    // Streams frames until valid drops, recording anomalies against the byte model.
    task automatic stream_frames(input int owner, input bit stall, output int xfers,
                                 output int bad, output int stalls);
        int  c;
        bit  xfer_now;
        logic [1:0] oh;
        oh     = 2'(1 << owner);
        xfers  = 0;
        bad    = 0;
        stalls = 0;
        c      = 0;
        while (frm_valid_o === 1'b1 && c < 200) begin
            frm_ready_i = stall ? (c % 4 == 3) : 1'b1;
            if (frm_data_o !== exp_frame(owner, xfers) || rd_addr_o !== 4'(xfers) ||
                mode_o !== 2'b01 || grant_o !== oh) bad++;
            if (!frm_ready_i) stalls++;
            xfer_now = frm_ready_i;
            tick();
            if (xfer_now) xfers++;
            c++;
        end
        frm_ready_i = 1'b0;
    endtask

    // From DRAIN with the serializer idle: enter RUN, pulse done, observe RELEASE and IDLE.
    task automatic complete_run(input bit drop_req, output logic [1:0] mode_run,
                                output logic [1:0] ack_obs, output logic err_obs,
                                output logic [1:0] mode_rel, output logic [1:0] grant_after,
                                output logic [3:0] addr_after);
        ser_busy_i = 1'b0;
        tick();
        mode_run = mode_o;
        done_i   = 1'b1;
        tick();
        ack_obs  = ack_o;
        err_obs  = err_o;
        mode_rel = mode_o;
        done_i   = 1'b0;
        if (drop_req) req_i = 2'b00;
        tick();
        grant_after = grant_o;
        addr_after  = rd_addr_o;
    endtask

    task automatic test_reset();
        req_i = 2'b00; frm_ready_i = 1'b0; ser_busy_i = 1'b0; done_i = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (grant_o !== 2'b00 || rd_addr_o !== 4'h0 || frm_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_link: grant=%b addr=%h valid=%b required 00/0/0", grant_o, rd_addr_o, frm_valid_o);
        end
        checks++;
        if (mode_o !== 2'b00 || ack_o !== 2'b00 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: mode=%b ack=%b err=%b required 00/00/0", mode_o, ack_o, err_o);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant_o !== 2'b00 || mode_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: grant=%b mode=%b required 00/00", grant_o, mode_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_load();
        int cyc, xf, bad, st;
        logic [1:0] m_run, ack, m_rel, g_aft;
        logic err;
        logic [3:0] a_aft;
        req_i = 2'b01;
        wait_grant(cyc);
        checks++;
        if (cyc != 2 || grant_o !== 2'b01) begin
            failures++;
            $display("FAIL grant_latency: cycles=%0d grant=%b required 2/01", cyc, grant_o);
        end
        checks++;
        if (frm_data_o !== 13'h0A00 || frm_valid_o !== 1'b1 || mode_o !== 2'b01) begin
            failures++;
            $display("FAIL first_frame: data=%h valid=%b mode=%b required 0a00/1/01", frm_data_o, frm_valid_o, mode_o);
        end
        stream_frames(0, 1'b0, xf, bad, st);
        checks++;
        if (xf != 16 || bad != 0) begin
            failures++;
            $display("FAIL single_stream: transfers=%0d bad=%0d required 16/0", xf, bad);
        end
        checks++;
        if (frm_valid_o !== 1'b0 || mode_o !== 2'b01 || rd_addr_o !== 4'hF) begin
            failures++;
            $display("FAIL drain_state: valid=%b mode=%b addr=%h required 0/01/f", frm_valid_o, mode_o, rd_addr_o);
        end
        complete_run(1'b1, m_run, ack, err, m_rel, g_aft, a_aft);
        checks++;
        if (m_run !== 2'b11 || ack !== 2'b01 || m_rel !== 2'b00 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_release: run_mode=%b ack=%b mode=%b err=%b required 11/01/00/0", m_run, ack, m_rel, err);
        end
        checks++;
        if (g_aft !== 2'b00 || a_aft !== 4'h0) begin
            failures++;
            $display("FAIL single_idle: grant=%b addr=%h required 00/0", g_aft, a_aft);
        end
        $display("test_single_load done");
    endtask

    task automatic test_backpressure();
        int cyc, xf, bad, st;
        logic [1:0] m_run, ack, m_rel, g_aft;
        logic err;
        logic [3:0] a_aft;
        req_i = 2'b01;
        wait_grant(cyc);
        stream_frames(0, 1'b1, xf, bad, st);
        checks++;
        if (xf != 16 || bad != 0 || st != 48) begin
            failures++;
            $display("FAIL backpressure: transfers=%0d bad=%0d stalls=%0d required 16/0/48", xf, bad, st);
        end
        complete_run(1'b1, m_run, ack, err, m_rel, g_aft, a_aft);
        checks++;
        if (ack !== 2'b01 || g_aft !== 2'b00) begin
            failures++;
            $display("FAIL bp_release: ack=%b grant_after=%b required 01/00", ack, g_aft);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_round_robin();
        int cyc, xf, bad, st;
        logic [1:0] m_run, ack, m_rel, g_aft, exp_g;
        logic err;
        logic [3:0] a_aft;
        do_reset();
        req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant(cyc);
            checks++;
            if (cyc != 2 || grant_o !== exp_g) begin
                failures++;
                $display("FAIL rr_grant%0d: cycles=%0d grant=%b required 2/%b", i, cyc, grant_o, exp_g);
            end
            stream_frames(i % 2, 1'b0, xf, bad, st);
            complete_run(i == 3, m_run, ack, err, m_rel, g_aft, a_aft);
            checks++;
            if (xf != 16 || bad != 0 || ack !== exp_g) begin
                failures++;
                $display("FAIL rr_ack%0d: transfers=%0d bad=%0d ack=%b required 16/0/%b", i, xf, bad, ack, exp_g);
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_done_ignored();
        int cyc, xf, bad, st, odd;
        req_i = 2'b01;
        ser_busy_i = 1'b1;
        wait_grant(cyc);
        done_i = 1'b1;
        stream_frames(0, 1'b0, xf, bad, st);
        odd = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (mode_o !== 2'b01 || ack_o !== 2'b00) odd++;
        end
        checks++;
        if (xf != 16 || bad != 0 || odd != 0) begin
            failures++;
            $display("FAIL done_in_load: transfers=%0d bad=%0d drain_anomalies=%0d required 16/0/0", xf, bad, odd);
        end
        done_i = 1'b0;
        ser_busy_i = 1'b0;
        tick();
        odd = 0;
        for (int i = 0; i < 3; i++) begin
            if (mode_o !== 2'b11 || ack_o !== 2'b00) odd++;
            tick();
        end
        checks++;
        if (odd != 0 || mode_o !== 2'b11) begin
            failures++;
            $display("FAIL run_waits: anomalies=%0d mode=%b required 0/11", odd, mode_o);
        end
        done_i = 1'b1;
        tick();
        checks++;
        if (ack_o !== 2'b01 || mode_o !== 2'b00) begin
            failures++;
            $display("FAIL fresh_done: ack=%b mode=%b required 01/00", ack_o, mode_o);
        end
        done_i = 1'b0;
        req_i = 2'b00;
        tick();
        $display("test_done_ignored done");
    endtask

    task automatic test_reset_mid_load();
        int cyc, xf, bad, st;
        logic [1:0] m_run, ack, m_rel, g_aft;
        logic err;
        logic [3:0] a_aft;
        req_i = 2'b01;
        frm_ready_i = 1'b1;
        wait_grant(cyc);
        frm_ready_i = 1'b1;
        repeat (7) tick();
        checks++;
        if (rd_addr_o !== 4'h7) begin
            failures++;
            $display("FAIL mid_addr: addr=%h required 7", rd_addr_o);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (grant_o !== 2'b00 || frm_valid_o !== 1'b0 || mode_o !== 2'b00 || rd_addr_o !== 4'h0) begin
            failures++;
            $display("FAIL async_reset: grant=%b valid=%b mode=%b addr=%h required 00/0/00/0",
                     grant_o, frm_valid_o, mode_o, rd_addr_o);
        end
        frm_ready_i = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_grant(cyc);
        checks++;
        if (cyc != 2 || rd_addr_o !== 4'h0 || frm_data_o !== 13'h0A00) begin
            failures++;
            $display("FAIL restart: cycles=%0d addr=%h data=%h required 2/0/0a00", cyc, rd_addr_o, frm_data_o);
        end
        stream_frames(0, 1'b0, xf, bad, st);
        complete_run(1'b1, m_run, ack, err, m_rel, g_aft, a_aft);
        checks++;
        if (xf != 16 || bad != 0 || ack !== 2'b01) begin
            failures++;
            $display("FAIL restart_load: transfers=%0d bad=%0d ack=%b required 16/0/01", xf, bad, ack);
        end
        $display("test_reset_mid_load done");
    endtask

    task automatic test_timeout();
        int cyc, xf, bad, st, odd;
        req_i = 2'b01;
        wait_grant(cyc);
        stream_frames(0, 1'b0, xf, bad, st);
        ser_busy_i = 1'b0;
        tick();
        checks++;
        if (mode_o !== 2'b11) begin
            failures++;
            $display("FAIL run_entry: mode=%b required 11", mode_o);
        end
        odd = 0;
`ifdef LOAD_TIMEOUT_EN
        for (int n = 1; n < 8; n++) begin
            tick();
            if (ack_o !== 2'b00 || err_o !== 1'b0) odd++;
        end
        tick();
        checks++;
        if (odd != 0 || ack_o !== 2'b01 || err_o !== 1'b1) begin
            failures++;
            $display("FAIL watchdog: early=%0d ack=%b err=%b required 0/01/1", odd, ack_o, err_o);
        end
        req_i = 2'b00;
        tick();
        checks++;
        if (err_o !== 1'b0 || grant_o !== 2'b00) begin
            failures++;
            $display("FAIL watchdog_after: err=%b grant=%b required 0/00", err_o, grant_o);
        end
`else
        for (int n = 0; n < 20; n++) begin
            tick();
            if (mode_o !== 2'b11 || ack_o !== 2'b00 || err_o !== 1'b0) odd++;
        end
        checks++;
        if (odd != 0) begin
            failures++;
            $display("FAIL no_watchdog: anomalies=%0d required 0", odd);
        end
        done_i = 1'b1;
        tick();
        checks++;
        if (ack_o !== 2'b01 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL late_done: ack=%b err=%b required 01/0", ack_o, err_o);
        end
        done_i = 1'b0;
        req_i = 2'b00;
        tick();
`endif
        $display("test_timeout done");
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_backpressure();
        test_round_robin();
        test_done_ignored();
        test_reset_mid_load();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
